// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU and its round-robin front end.
package alu_pkg;

    // Default datapath widths
    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;
    localparam int ALU_FLAG_W = 4;

    // Arbiter sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // ALU opcodes (the arbiter forwards these untouched)
    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd7;

    // ALU flag bit positions
    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: search starts one past the last grant
// and wraps modulo N_REQ; returns a one-hot grant plus its index.
module rr_pick
    import alu_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    // Walk the requesters in priority order and take the first valid one
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IDX_W'((int'(i_last_grant) + k) % N_REQ);
            if (!w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                w_found         = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end sharing one combinational ALU among N_REQ requesters.
// One operation in flight: accept (IDLE) -> ALU evaluate (EXEC) -> respond (RESP).
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W,
    parameter int FLAG_W = ALU_FLAG_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*OP_W-1:0]   req_op,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [OP_W-1:0]         alu_op,
    input  logic [DATA_W-1:0]       alu_y,
    input  logic [FLAG_W-1:0]       alu_flags,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_y,
    output logic [FLAG_W-1:0]       rsp_flags,
    output logic                    busy
);

    localparam int IDX_W = $clog2(N_REQ);

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [IDX_W-1:0]  r_last_grant;
    logic [IDX_W-1:0]  r_cur_grant;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic [DATA_W-1:0] r_rsp_y;
    logic [FLAG_W-1:0] r_rsp_flags;
    logic [N_REQ-1:0]  r_rsp_valid;
    logic              r_busy;

    logic [N_REQ-1:0]  w_pick_grant;
    logic [IDX_W-1:0]  w_pick_idx;
    logic [N_REQ-1:0]  w_req_ready;
    logic              w_accept;
    logic              w_handshake;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic [OP_W-1:0]   w_sel_op;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick_grant),
        .o_idx        (w_pick_idx)
    );

    assign w_sel_a  = req_a[int'(w_pick_idx)*DATA_W +: DATA_W];
    assign w_sel_b  = req_b[int'(w_pick_idx)*DATA_W +: DATA_W];
    assign w_sel_op = req_op[int'(w_pick_idx)*OP_W +: OP_W];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, same-cycle grant and handshake decode
    always_comb begin
        w_next      = r_state;
        w_req_ready = '0;
        w_accept    = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_next      = EXEC;
                    w_accept    = 1'b1;
                    w_req_ready = w_pick_grant;
                end else begin
                    w_next = IDLE;
                end
            end
            EXEC: begin
                w_next = RESP;
            end
            RESP: begin
                // Only the owner's ready completes the response
                if (rsp_ready[r_cur_grant]) begin
                    w_handshake = 1'b1;
                    w_next      = IDLE;
                end else begin
                    w_next = RESP;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand latch, result capture, grant bookkeeping and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= IDX_W'(N_REQ - 1);
            r_cur_grant  <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_y      <= '0;
            r_rsp_flags  <= '0;
            r_rsp_valid  <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_a     <= w_sel_a;
                        r_alu_b     <= w_sel_b;
                        r_alu_op    <= w_sel_op;
                        r_cur_grant <= w_pick_idx;
                        r_busy      <= 1'b1;
                    end
                end
                EXEC: begin
                    r_rsp_y     <= alu_y;
                    r_rsp_flags <= alu_flags;
                    r_rsp_valid <= idx_to_onehot(r_cur_grant);
                end
                RESP: begin
                    if (w_handshake) begin
                        r_last_grant <= r_cur_grant;
                        r_rsp_valid  <= '0;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= '0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign rsp_flags = r_rsp_flags;
    assign busy      = r_busy;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed and randomized bench for alu_rr_arbiter with a behavioural ALU
// and a queue-free round-robin reference model.
module tb_alu_rr_arbiter;
    import alu_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int OW = 4;
    localparam int FW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*DW-1:0] req_a, req_b;
    logic [N*OW-1:0] req_op;
    logic [DW-1:0]   alu_a, alu_b, alu_y, rsp_y;
    logic [OW-1:0]   alu_op;
    logic [FW-1:0]   alu_flags, rsp_flags;
    logic            busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          pend [N];
    logic [31:0] ma [N];
    logic [31:0] mb [N];
    logic [3:0]  mo [N];
    int          last_g;

    alu_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .FLAG_W(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {flags[N,Z,C,V], y}
    function automatic logic [35:0] alu_calc(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
        logic [32:0] w;
        logic [31:0] y;
        logic c, v;
        c = 1'b0; v = 1'b0;
        case (op)
            ALU_ADD: begin w = {1'b0, a} + {1'b0, b}; y = w[31:0]; c = w[32];
                           v = (a[31] == b[31]) && (y[31] != a[31]); end
            ALU_SUB: begin w = {1'b0, a} - {1'b0, b}; y = w[31:0]; c = w[32];
                           v = (a[31] != b[31]) && (y[31] != a[31]); end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << b[4:0];
            ALU_SRL: y = a >> b[4:0];
            default: y = b;
        endcase
        return {y[31], (y == 32'd0), c, v, y};
    endfunction

    assign {alu_flags, alu_y} = alu_calc(alu_a, alu_b, alu_op);

    function automatic logic [3:0] oh4(input int i);
        return 4'd1 << i;
    endfunction

    // Round-robin rule: first pending index after the last grant, wrapping
    function automatic int exp_winner();
        for (int k = 1; k <= N; k++) begin
            if (pend[(last_g + k) % N]) return (last_g + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_req(input int i);
        pend[i] = 1'b1;
        ma[i]   = $urandom;
        mb[i]   = $urandom;
        mo[i]   = 4'($urandom_range(0, 7));
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pend[i];
            req_a[i*DW +: DW]     = ma[i];
            req_b[i*DW +: DW]     = mb[i];
            req_op[i*OW +: OW]    = mo[i];
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        last_g = N - 1;
        drive_reqs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_alu_a",     64'(alu_a),     64'd0);
        chk("rst_alu_b",     64'(alu_b),     64'd0);
        chk("rst_alu_op",    64'(alu_op),    64'd0);
        chk("rst_rsp_y",     64'(rsp_y),     64'd0);
        chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
    endtask

    // One full transaction from an IDLE cycle with requests already driven.
    // bp: RESP cycles with the owner's ready low; others_hi: hold every other
    // rsp_ready bit high meanwhile; refill: winner re-requests right away.
    task automatic do_txn(input int bp, input bit others_hi, input bit refill);
        int          w;
        logic [3:0]  oh, rr;
        logic [31:0] ea, eb;
        logic [3:0]  eo;
        logic [35:0] er;
        w = exp_winner();
        if (w < 0) begin
            chk("idle_no_grant", 64'(req_ready), 64'd0);
            @(negedge clk);
            return;
        end
        oh = oh4(w);
        ea = ma[w]; eb = mb[w]; eo = mo[w];
        er = alu_calc(ea, eb, eo);
        chk("grant",     64'(req_ready), 64'(oh));
        chk("idle_busy", 64'(busy),      64'd0);
        @(negedge clk);
        pend[w] = 1'b0;
        if (refill) new_req(w);
        drive_reqs();
        rsp_ready = 4'($urandom);
        #1;
        chk("exec_busy",      64'(busy),      64'd1);
        chk("exec_req_ready", 64'(req_ready), 64'd0);
        chk("exec_alu_a",     64'(alu_a),     64'(ea));
        chk("exec_alu_b",     64'(alu_b),     64'(eb));
        chk("exec_alu_op",    64'(alu_op),    64'(eo));
        chk("exec_rsp_valid", 64'(rsp_valid), 64'd0);
        for (int j = 0; j <= bp; j++) begin
            @(negedge clk);
            rr = others_hi ? ~oh : (4'($urandom) & ~oh);
            if (j == bp) rr = rr | oh;
            rsp_ready = rr;
            #1;
            chk("resp_valid",     64'(rsp_valid), 64'(oh));
            chk("resp_y",         64'(rsp_y),     64'(er[31:0]));
            chk("resp_flags",     64'(rsp_flags), 64'(er[35:32]));
            chk("resp_req_ready", 64'(req_ready), 64'd0);
            chk("resp_busy",      64'(busy),      64'd1);
            chk("resp_alu_a",     64'(alu_a),     64'(ea));
        end
        @(negedge clk);
        last_g    = w;
        rsp_ready = '0;
        #1;
        chk("done_busy",      64'(busy),      64'd0);
        chk("done_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("done_alu_a",     64'(alu_a),     64'(ea));
    endtask

    initial begin
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '0;
        for (int i = 0; i < N; i++) begin ma[i] = '0; mb[i] = '0; mo[i] = '0; end
        do_reset();

        // Single request from requester 2: 5 + 7
        @(negedge clk);
        pend[2] = 1'b1; ma[2] = 32'd5; mb[2] = 32'd7; mo[2] = ALU_ADD;
        drive_reqs(); #1;
        chk("single_grant_const", 64'(req_ready), 64'h4);
        do_txn(0, 1'b0, 1'b0);
        chk("single_sum_const", 64'(rsp_y), 64'd12);

        // Back-pressure: requester 1 wins over 0 (last grant 0), stalls 5 cycles
        new_req(0); drive_reqs(); #1;
        do_txn(0, 1'b0, 1'b0);
        new_req(0); new_req(1); drive_reqs(); #1;
        do_txn(5, 1'b0, 1'b0);
        chk("bp_next_grant", 64'(req_ready), 64'h1);
        do_txn(0, 1'b0, 1'b0);

        // Wrong-requester ready: others' ready held high during RESP of 2
        new_req(2); drive_reqs(); #1;
        do_txn(3, 1'b1, 1'b0);

        // Reset in EXEC with requester 3 in flight
        new_req(3); ma[3] = 32'hdead_beef; mb[3] = 32'h1234_5678; drive_reqs(); #1;
        chk("rst3_grant", 64'(req_ready), 64'h8);
        @(negedge clk);
        pend[3] = 1'b0; drive_reqs(); #1;
        chk("rst3_exec_alu_a", 64'(alu_a), 64'hdead_beef);
        rst_n = 1'b0;
        #1;
        chk("async_busy",      64'(busy),      64'd0);
        chk("async_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("async_alu_a",     64'(alu_a),     64'd0);
        chk("async_alu_b",     64'(alu_b),     64'd0);
        do_reset();

        // Wrap-around: 0 and 3 valid with last grant 3 -> 0, then 3
        @(negedge clk);
        new_req(0); new_req(3); drive_reqs(); #1;
        chk("wrap_first", 64'(req_ready), 64'h1);
        do_txn(0, 1'b0, 1'b0);
        new_req(0); drive_reqs(); #1;
        chk("wrap_second", 64'(req_ready), 64'h8);
        do_txn(0, 1'b0, 1'b0);

        // All four requesting continuously from reset: 0,1,2,3,0 every 3 cycles
        do_reset();
        for (int i = 0; i < N; i++) new_req(i);
        drive_reqs(); #1;
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", 64'(req_ready), 64'(oh4(i % N)));
            do_txn(0, 1'b0, 1'b1);
        end

        // Randomized traffic with back-pressure and stray ready bits
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) new_req(i);
            end
            drive_reqs(); #1;
            do_txn(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
